// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates a tag per dispatched instruction, collects CDB
// results, resolves source operands and retires completed entries in program order.
module reorder_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_DEPTH    = 64,
    parameter int REGMAP_DEPTH = 32,
    localparam int REG_ADDR_WIDTH = $clog2(REGMAP_DEPTH),
    localparam int TAG_WIDTH      = $clog2(ROB_DEPTH)
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        i_flush,
    input  logic                        i_dispatch_en,
    input  logic [REG_ADDR_WIDTH-1:0]   i_dispatch_rdest,
    input  logic [2*REG_ADDR_WIDTH-1:0] i_dispatch_rsrc,
    output logic                        o_dispatch_stall,
    output logic [1:0]                  o_src_rdy,
    output logic [2*DATA_WIDTH-1:0]     o_src_data,
    output logic [2*TAG_WIDTH-1:0]      o_src_tag,
    input  logic                        i_cdb_en,
    input  logic [TAG_WIDTH-1:0]        i_cdb_tag,
    input  logic [DATA_WIDTH-1:0]       i_cdb_data,
    output logic                        o_dest_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]   o_dest_wr_rdest,
    output logic [DATA_WIDTH-1:0]       o_dest_wr_data,
    output logic                        o_tag_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]   o_tag_wr_rdest,
    output logic [TAG_WIDTH-1:0]        o_tag_wr_tag,
    output logic [2*REG_ADDR_WIDTH-1:0] o_lookup_rsrc,
    input  logic [1:0]                  i_lookup_rdy,
    input  logic [2*DATA_WIDTH-1:0]     i_lookup_data,
    input  logic [2*TAG_WIDTH-1:0]      i_lookup_tag,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam logic [TAG_WIDTH:0] PTR_ONE = {{TAG_WIDTH{1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [TAG_WIDTH:0]          head_q, head_d;
    logic [TAG_WIDTH:0]          tail_q, tail_d;
    logic [ROB_DEPTH-1:0]        rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0]       data_q  [ROB_DEPTH];
    logic [REG_ADDR_WIDTH-1:0]   rdest_q [ROB_DEPTH];

    logic [TAG_WIDTH-1:0] head_idx;
    logic [TAG_WIDTH-1:0] tail_idx;
    logic                 accept;
    logic                 retire;
    logic                 cdb_wr;

    assign head_idx = head_q[TAG_WIDTH-1:0];
    assign tail_idx = tail_q[TAG_WIDTH-1:0];

    assign o_empty = (head_q == tail_q);
    assign o_full  = (head_idx == tail_idx) && (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);

    assign accept           = i_dispatch_en && !o_full && !i_flush;
    assign o_dispatch_stall = i_dispatch_en && !accept;
    assign retire           = !o_empty && rdy_q[head_idx] && !i_flush;
    assign cdb_wr           = i_cdb_en && !i_flush;

    assign o_tag_wr_en    = accept;
    assign o_tag_wr_rdest = i_dispatch_rdest;
    assign o_tag_wr_tag   = tail_idx;

    assign o_dest_wr_en    = retire;
    assign o_dest_wr_rdest = rdest_q[head_idx];
    assign o_dest_wr_data  = data_q[head_idx];

    assign o_lookup_rsrc = i_dispatch_rsrc;

    // Register map first, then a completed entry, then a result on the bus this cycle.
    always_comb begin
        o_src_rdy  = '0;
        o_src_data = '0;
        o_src_tag  = i_lookup_tag;
        for (int i = 0; i < 2; i++) begin
            if (i_lookup_rdy[i]) begin
                o_src_rdy[i] = 1'b1;
                o_src_data[i*DATA_WIDTH +: DATA_WIDTH] = i_lookup_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (rdy_q[i_lookup_tag[i*TAG_WIDTH +: TAG_WIDTH]]) begin
                o_src_rdy[i] = 1'b1;
                o_src_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i_lookup_tag[i*TAG_WIDTH +: TAG_WIDTH]];
            end else if (i_cdb_en && (i_cdb_tag == i_lookup_tag[i*TAG_WIDTH +: TAG_WIDTH])) begin
                o_src_rdy[i] = 1'b1;
                o_src_data[i*DATA_WIDTH +: DATA_WIDTH] = i_cdb_data;
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        rdy_d  = rdy_q;
        if (i_flush) begin
            head_d = '0;
            tail_d = '0;
            rdy_d  = '0;
        end else begin
            if (cdb_wr) begin
                rdy_d[i_cdb_tag] = 1'b1;
            end
            // Allocation wins over a stray broadcast to the slot being claimed.
            if (accept) begin
                rdy_d[tail_idx] = 1'b0;
                tail_d          = tail_q + PTR_ONE;
            end
            if (retire) begin
                head_d = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            rdy_q  <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cdb_wr) begin
            data_q[i_cdb_tag] <= i_cdb_data;
        end
        if (accept) begin
            rdest_q[tail_idx] <= i_dispatch_rdest;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; the bench plays the register map on the lookup ports.
module tb_reorder_buffer;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int TW  = 6;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            i_flush;
    logic            i_dispatch_en;
    logic [RAW-1:0]  i_dispatch_rdest;
    logic [2*RAW-1:0] i_dispatch_rsrc;
    logic            o_dispatch_stall;
    logic [1:0]      o_src_rdy;
    logic [2*DW-1:0] o_src_data;
    logic [2*TW-1:0] o_src_tag;
    logic            i_cdb_en;
    logic [TW-1:0]   i_cdb_tag;
    logic [DW-1:0]   i_cdb_data;
    logic            o_dest_wr_en;
    logic [RAW-1:0]  o_dest_wr_rdest;
    logic [DW-1:0]   o_dest_wr_data;
    logic            o_tag_wr_en;
    logic [RAW-1:0]  o_tag_wr_rdest;
    logic [TW-1:0]   o_tag_wr_tag;
    logic [2*RAW-1:0] o_lookup_rsrc;
    logic [1:0]      i_lookup_rdy;
    logic [2*DW-1:0] i_lookup_data;
    logic [2*TW-1:0] i_lookup_tag;
    logic            o_full;
    logic            o_empty;

    int vectors = 0;
    int miscompares = 0;

    reorder_buffer dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_flush          (i_flush),
        .i_dispatch_en    (i_dispatch_en),
        .i_dispatch_rdest (i_dispatch_rdest),
        .i_dispatch_rsrc  (i_dispatch_rsrc),
        .o_dispatch_stall (o_dispatch_stall),
        .o_src_rdy        (o_src_rdy),
        .o_src_data       (o_src_data),
        .o_src_tag        (o_src_tag),
        .i_cdb_en         (i_cdb_en),
        .i_cdb_tag        (i_cdb_tag),
        .i_cdb_data       (i_cdb_data),
        .o_dest_wr_en     (o_dest_wr_en),
        .o_dest_wr_rdest  (o_dest_wr_rdest),
        .o_dest_wr_data   (o_dest_wr_data),
        .o_tag_wr_en      (o_tag_wr_en),
        .o_tag_wr_rdest   (o_tag_wr_rdest),
        .o_tag_wr_tag     (o_tag_wr_tag),
        .o_lookup_rsrc    (o_lookup_rsrc),
        .i_lookup_rdy     (i_lookup_rdy),
        .i_lookup_data    (i_lookup_data),
        .i_lookup_tag     (i_lookup_tag),
        .o_full           (o_full),
        .o_empty          (o_empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        i_flush = 1'b0;
        i_dispatch_en = 1'b0;
        i_dispatch_rdest = '0;
        i_dispatch_rsrc = '0;
        i_cdb_en = 1'b0;
        i_cdb_tag = '0;
        i_cdb_data = '0;
        i_lookup_rdy = '0;
        i_lookup_data = '0;
        i_lookup_tag = '0;

        // Reset state
        #2;
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        chk("rst_stall", o_dispatch_stall, 0);
        chk("rst_dest_wr", o_dest_wr_en, 0);
        chk("rst_tag_wr", o_tag_wr_en, 0);
        #10 n_rst = 1'b1;
        tick();

        // First dispatch gets tag 0 in the same cycle
        i_dispatch_en = 1'b1;
        i_dispatch_rdest = 5'd5;
        #1;
        chk("d0_tag_wr_en", o_tag_wr_en, 1);
        chk("d0_tag_wr_rdest", o_tag_wr_rdest, 5);
        chk("d0_tag_wr_tag", o_tag_wr_tag, 0);
        chk("d0_stall", o_dispatch_stall, 0);
        tick();
        chk("d0_not_empty", o_empty, 0);
        i_dispatch_rdest = 5'd7;
        #1;
        chk("d1_tag", o_tag_wr_tag, 1);
        tick();
        i_dispatch_en = 1'b0;

        // Out-of-order completion, in-order retirement
        i_cdb_en = 1'b1; i_cdb_tag = 6'd1; i_cdb_data = 32'h11;
        #1;
        chk("ooo_no_retire_a", o_dest_wr_en, 0);
        tick();
        i_cdb_tag = 6'd0; i_cdb_data = 32'h22;
        #1;
        chk("ooo_no_retire_b", o_dest_wr_en, 0);
        tick();
        i_cdb_en = 1'b0;
        #1;
        chk("ret0_en", o_dest_wr_en, 1);
        chk("ret0_rdest", o_dest_wr_rdest, 5);
        chk("ret0_data", o_dest_wr_data, 32'h22);
        tick();
        chk("ret1_en", o_dest_wr_en, 1);
        chk("ret1_rdest", o_dest_wr_rdest, 7);
        chk("ret1_data", o_dest_wr_data, 32'h11);
        tick();
        chk("ret_done_en", o_dest_wr_en, 0);
        chk("ret_done_empty", o_empty, 1);

        // Operand resolution: tags 2 and 3
        i_dispatch_en = 1'b1; i_dispatch_rdest = 5'd10;
        #1;
        chk("d2_tag", o_tag_wr_tag, 2);
        tick();
        i_dispatch_rdest = 5'd11;
        #1;
        chk("d3_tag", o_tag_wr_tag, 3);
        tick();
        i_dispatch_en = 1'b0;
        i_cdb_en = 1'b1; i_cdb_tag = 6'd3; i_cdb_data = 32'hABCD;
        tick();
        i_cdb_en = 1'b0;
        i_dispatch_rsrc = {5'd4, 5'd9};
        i_lookup_rdy = 2'b10;
        i_lookup_data = {32'h5555, 32'h0};
        i_lookup_tag = {6'd9, 6'd3};
        #1;
        chk("head2_not_ready", o_dest_wr_en, 0);
        chk("op_rsrc", o_lookup_rsrc, {5'd4, 5'd9});
        chk("op_rdy_entry", o_src_rdy, 2'b11);
        chk("op_data_entry", o_src_data, {32'h5555, 32'hABCD});
        chk("op_tag", o_src_tag, {6'd9, 6'd3});
        i_lookup_tag = {6'd9, 6'd2};
        #1;
        chk("op_rdy_wait", o_src_rdy, 2'b10);
        chk("op_tag_wait", o_src_tag, {6'd9, 6'd2});
        i_cdb_en = 1'b1; i_cdb_tag = 6'd2; i_cdb_data = 32'h1234;
        #1;
        chk("op_rdy_cdb", o_src_rdy, 2'b11);
        chk("op_data_cdb", o_src_data[31:0], 32'h1234);
        tick();
        i_cdb_en = 1'b0;
        #1;
        chk("op_data_entry2", o_src_data[31:0], 32'h1234);
        chk("ret2_en", o_dest_wr_en, 1);
        chk("ret2_rdest", o_dest_wr_rdest, 10);
        chk("ret2_data", o_dest_wr_data, 32'h1234);
        tick();
        chk("ret3_rdest", o_dest_wr_rdest, 11);
        chk("ret3_data", o_dest_wr_data, 32'hABCD);
        tick();
        chk("ret3_done_empty", o_empty, 1);
        i_lookup_rdy = '0;

        // Flush with 10 entries in flight (tags 4..13), head ready
        for (int i = 0; i < 10; i++) begin
            i_dispatch_en = 1'b1;
            i_dispatch_rdest = RAW'(i + 1);
            tick();
        end
        i_dispatch_en = 1'b0;
        i_cdb_en = 1'b1; i_cdb_tag = 6'd4; i_cdb_data = 32'h44;
        tick();
        i_cdb_en = 1'b0;
        #1;
        chk("pre_flush_ret", o_dest_wr_en, 1);
        chk("pre_flush_rdest", o_dest_wr_rdest, 1);
        i_flush = 1'b1;
        i_dispatch_en = 1'b1; i_dispatch_rdest = 5'd20;
        i_cdb_en = 1'b1; i_cdb_tag = 6'd5; i_cdb_data = 32'h55;
        #1;
        chk("flush_dest_wr", o_dest_wr_en, 0);
        chk("flush_tag_wr", o_tag_wr_en, 0);
        chk("flush_stall", o_dispatch_stall, 1);
        tick();
        i_flush = 1'b0; i_dispatch_en = 1'b0; i_cdb_en = 1'b0;
        #1;
        chk("post_flush_empty", o_empty, 1);
        chk("post_flush_dest_wr", o_dest_wr_en, 0);
        i_lookup_tag = {6'd0, 6'd5};
        #1;
        chk("flush_cdb_ignored", o_src_rdy, 2'b00);
        i_dispatch_en = 1'b1; i_dispatch_rdest = 5'd3;
        #1;
        chk("post_flush_tag_en", o_tag_wr_en, 1);
        chk("post_flush_tag", o_tag_wr_tag, 0);
        tick();
        i_dispatch_en = 1'b0;
        #1;
        chk("post_flush_rdy_clear", o_dest_wr_en, 0);

        // Asynchronous reset with 5 entries in flight
        for (int i = 0; i < 4; i++) begin
            i_dispatch_en = 1'b1;
            i_dispatch_rdest = RAW'(i + 12);
            tick();
        end
        i_dispatch_en = 1'b0;
        i_cdb_en = 1'b1; i_cdb_tag = 6'd0; i_cdb_data = 32'h77;
        tick();
        i_cdb_en = 1'b0;
        #1;
        chk("pre_rst_ret", o_dest_wr_en, 1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_empty", o_empty, 1);
        chk("mid_rst_dest_wr", o_dest_wr_en, 0);
        #10 n_rst = 1'b1;
        tick();
        chk("post_rst_no_retire", o_dest_wr_en, 0);
        chk("post_rst_empty", o_empty, 1);

        // Fill all 64 entries, then wrap
        for (int i = 0; i < 64; i++) begin
            i_dispatch_en = 1'b1;
            i_dispatch_rdest = RAW'(i);
            #1;
            chk("fill_tag", o_tag_wr_tag, 64'(i));
            tick();
        end
        #1;
        chk("full_set", o_full, 1);
        chk("full_stall", o_dispatch_stall, 1);
        chk("full_tag_wr", o_tag_wr_en, 0);
        chk("full_not_empty", o_empty, 0);
        i_cdb_en = 1'b1; i_cdb_tag = 6'd0; i_cdb_data = 32'h99;
        tick();
        i_cdb_en = 1'b0;
        #1;
        chk("full_retire_en", o_dest_wr_en, 1);
        chk("full_retire_data", o_dest_wr_data, 32'h99);
        chk("full_stall_during_retire", o_dispatch_stall, 1);
        tick();
        chk("wrap_not_full", o_full, 0);
        chk("wrap_tag_en", o_tag_wr_en, 1);
        chk("wrap_tag", o_tag_wr_tag, 0);
        chk("wrap_stall", o_dispatch_stall, 0);
        tick();
        i_dispatch_en = 1'b0;
        #1;
        chk("wrap_full_again", o_full, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register/result data width.
REQ-002 SHALL have parameter ROB_DEPTH, default 64: entry count, power of two.
REQ-003 SHALL have parameter REGMAP_DEPTH, default 32: architectural register count; REG_ADDR_WIDTH = clog2(REGMAP_DEPTH).
REQ-004 SHALL have localparam TAG_WIDTH = clog2(ROB_DEPTH): tag = entry index.
REQ-005 SHALL have port clk  in  1: the single clock, all state on rising edge.
REQ-006 SHALL have port n_rst  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_flush  in  1: discard all in-flight entries.
REQ-008 SHALL have port i_dispatch_en  in  1: new instruction offered.
REQ-009 SHALL have port i_dispatch_rdest  in  REG_ADDR_WIDTH: destination register of the offered instruction.
REQ-010 SHALL have port i_dispatch_rsrc  in  2 x REG_ADDR_WIDTH: source registers of the offered instruction.
REQ-011 SHALL have port o_dispatch_stall  out  1: offer not accepted this cycle.
REQ-012 SHALL have ports o_src_rdy  out  2 x 1, o_src_data  out  2 x DATA_WIDTH and o_src_tag  out  2 x TAG_WIDTH: resolved operands.
REQ-013 SHALL have ports i_cdb_en  in  1, i_cdb_tag  in  TAG_WIDTH and i_cdb_data  in  DATA_WIDTH: result broadcast.
REQ-014 SHALL have port dest_wr  regmap_dest_wr_if.source  (wr_en 1, rdest REG_ADDR_WIDTH, data DATA_WIDTH): retire writeback to the register map.
REQ-015 SHALL have port tag_wr  regmap_tag_wr_if.source  (wr_en 1, rdest REG_ADDR_WIDTH, tag TAG_WIDTH): rename update.
REQ-016 SHALL have port regmap_lookup[0:1]  regmap_lookup_if.source: drives rsrc; samples rdy, data, tag.
REQ-017 SHALL have ports o_full  out  1 and o_empty  out  1: occupancy status.

Function
REQ-018 SHALL keep per-entry rdy, rdest and data, plus head/tail pointers of TAG_WIDTH+1 bits each; the MSB is the wrap bit.
REQ-019 SHALL assert o_empty when head == tail, and o_full when indices match and wrap bits differ.
REQ-020 SHALL accept dispatch when i_dispatch_en && !o_full && !i_flush; o_dispatch_stall = i_dispatch_en && !accept.
REQ-021 SHALL, on accept, drive in the same cycle tag_wr.wr_en=1, rdest=i_dispatch_rdest, tag=tail index; on the edge, write entry[tail] with rdy=0 and rdest, and increment tail modulo 2*ROB_DEPTH.
REQ-022 SHALL drive tag_wr.wr_en=1 even when rdest is r0; r0 filtering belongs to the register map, and the entry still allocates and retires.
REQ-023 SHALL drive regmap_lookup[i].rsrc = i_dispatch_rsrc[i] combinationally.
REQ-024 SHALL resolve operand i combinationally, first match wins:
- lookup.rdy=1: rdy=1, data=lookup.data.
- entry[lookup.tag].rdy=1: rdy=1, data=entry data.
- i_cdb_en && i_cdb_tag==lookup.tag: rdy=1, data=i_cdb_data.
- otherwise: rdy=0, tag=lookup.tag.
o_src_tag SHALL always equal lookup.tag.
REQ-025 SHALL, on i_cdb_en, set entry[i_cdb_tag].data=i_cdb_data and rdy=1 at the edge; a broadcast to an unallocated entry is a don't-care.
REQ-026 SHALL retire when !o_empty && entry[head].rdy && !i_flush: drive dest_wr.wr_en=1, rdest and data of entry[head] combinationally; increment head at the edge; at most one retire per cycle.
REQ-027 SHALL make a broadcast to the head entry retire no earlier than the next cycle, since rdy is registered.
REQ-028 SHALL evaluate o_full from registered pointers, so a simultaneous retire does not unblock dispatch in the same cycle.
REQ-029 SHALL permit simultaneous dispatch and retire; the tail increment and head increment are independent.
REQ-030 SHALL, on i_flush:
- force dest_wr.wr_en=0 and tag_wr.wr_en=0 that cycle;
- at the edge, set head=tail=0 and clear all entry rdy bits;
- ignore a CDB broadcast in that cycle.

Reset
REQ-031 SHALL, on n_rst low, asynchronously set head=tail=0 and all rdy=0, giving o_empty=1, o_full=0, o_dispatch_stall=0 and dest_wr.wr_en=tag_wr.wr_en=0; entry data and rdest need no reset.
REQ-032 SHALL, on reset assertion mid-operation, discard all entries, with normal operation resuming on the first edge after release.

Verification
REQ-033 SHALL cover: after reset, dispatch rdest=5 -> tag_wr.wr_en=1, rdest=5, tag=0 the same cycle; o_empty=0 next cycle.
REQ-034 SHALL cover: dispatch to tags 0 and 1, CDB tag 1 then tag 0 -> retire of tag 0 exactly one cycle after tag 0's broadcast, tag 1 on the following cycle, in program order.
REQ-035 SHALL cover: dispatch 64 without retire -> o_full=1; 65th offer gives o_dispatch_stall=1; retire one -> next dispatch gets tag 0 with tail wrap bit toggled.
REQ-036 SHALL cover: lookup returns rdy=0 tag=3, entry 3 rdy with data 0xABCD -> o_src_rdy=1, o_src_data=0xABCD; with entry 3 not ready and a same-cycle CDB tag 3 data 0x1234 -> o_src_data=0x1234.
REQ-037 SHALL cover: 10 entries in flight with head ready, i_flush=1 -> no dest_wr or tag_wr that cycle; o_empty=1 next cycle; next dispatch gets tag 0.
REQ-038 SHALL cover: n_rst pulsed low with 5 entries in flight -> o_empty=1 immediately, with no retire after release.
